// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch PC generator.
package fetch_pkg;

    typedef enum logic [1:0] {BOOT, FETCH, HOLD, DISCARD} fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr,pc} holding register used when decode stalls with a full output slot.
module fetch_skid_buf #(
    parameter int WordSize = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                i_load,
    input  logic                i_unload,
    input  logic                i_clear,
    input  logic [WordSize-1:0] i_instr,
    input  logic [WordSize-1:0] i_pc,
    output logic                o_valid,
    output logic [WordSize-1:0] o_instr,
    output logic [WordSize-1:0] o_pc
);

    logic                r_valid;
    logic [WordSize-1:0] r_instr;
    logic [WordSize-1:0] r_pc;

    // Clear (redirect) beats load, load beats unload.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (i_unload) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: req/ack instruction fetch, stallable decode slot, execute redirects.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int                  WordSize    = 32,
    parameter logic [WordSize-1:0] ResetVector = '0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                stall,
    input  logic                redirect,
    input  logic [WordSize-1:0] redirect_addr,
    output logic                imem_req,
    output logic [WordSize-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [WordSize-1:0] imem_data,
    output logic                if_valid,
    output logic [WordSize-1:0] if_instr,
    output logic [WordSize-1:0] if_pc,
    output logic                flush,
    output logic                misalign
);

    fetch_state_t        r_state;
    logic [WordSize-1:0] r_pc;
    logic [WordSize-1:0] r_addr;
    logic                r_if_valid;
    logic [WordSize-1:0] r_if_instr;
    logic [WordSize-1:0] r_if_pc;
    logic                r_flush;
    logic                r_misalign;

    logic                w_ack;
    logic                w_slot_free;
    logic                w_skid_load;
    logic                w_skid_unload;
    logic                w_skid_valid;
    logic [WordSize-1:0] w_skid_instr;
    logic [WordSize-1:0] w_skid_pc;
    logic [WordSize-1:0] w_pc_inc;
    logic [WordSize-1:0] w_tgt;

    assign w_ack         = imem_ack && imem_req;
    assign w_slot_free   = !stall || !r_if_valid;
    assign w_pc_inc      = r_pc + WordSize'(PC_STEP);
    assign w_tgt         = {redirect_addr[WordSize-1:2], 2'b00};
    assign w_skid_load   = !redirect && (r_state == FETCH) && w_ack && !w_slot_free;
    assign w_skid_unload = !redirect && (r_state == HOLD) && !stall && w_skid_valid;

    fetch_skid_buf #(.WordSize(WordSize)) u_skid (
        .clk      (clk),
        .rstn     (rstn),
        .i_load   (w_skid_load),
        .i_unload (w_skid_unload),
        .i_clear  (redirect),
        .i_instr  (imem_data),
        .i_pc     (r_addr),
        .o_valid  (w_skid_valid),
        .o_instr  (w_skid_instr),
        .o_pc     (w_skid_pc)
    );

    // r_addr tracks the outstanding request address; it only diverges from r_pc in DISCARD.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= BOOT;
            r_pc       <= ResetVector;
            r_addr     <= ResetVector;
            r_if_valid <= 1'b0;
            r_if_instr <= WordSize'(NOP_INSTR);
            r_if_pc    <= '0;
            r_flush    <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_flush    <= redirect;
            r_misalign <= redirect && (redirect_addr[1:0] != 2'b00);
            if (!stall)
                r_if_valid <= 1'b0;
            if (redirect) begin
                r_pc       <= w_tgt;
                r_if_valid <= 1'b0;
                // An unanswered request must still complete before the new target goes out.
                if (imem_req && !imem_ack) begin
                    r_state <= DISCARD;
                end else begin
                    r_state <= FETCH;
                    r_addr  <= w_tgt;
                end
            end else begin
                case (r_state)
                    BOOT: begin
                        r_state <= FETCH;
                        r_addr  <= r_pc;
                    end
                    FETCH: begin
                        if (w_ack) begin
                            r_pc   <= w_pc_inc;
                            r_addr <= w_pc_inc;
                            if (w_slot_free) begin
                                r_if_valid <= 1'b1;
                                r_if_instr <= imem_data;
                                r_if_pc    <= r_addr;
                            end else begin
                                r_state <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (w_skid_unload) begin
                            r_if_valid <= 1'b1;
                            r_if_instr <= w_skid_instr;
                            r_if_pc    <= w_skid_pc;
                            r_state    <= FETCH;
                        end
                    end
                    DISCARD: begin
                        if (w_ack) begin
                            r_state <= FETCH;
                            r_addr  <= r_pc;
                        end
                    end
                    default: r_state <= BOOT;
                endcase
            end
        end
    end

    assign imem_req  = (r_state == FETCH) || (r_state == DISCARD);
    assign imem_addr = r_addr;
    assign if_valid  = r_if_valid;
    assign if_instr  = r_if_instr;
    assign if_pc     = r_if_pc;
    assign flush     = r_flush;
    assign misalign  = r_misalign;

endmodule
